// File: rtl/reg_wb_arbiter_pkg.sv
// rtl/reg_wb_arbiter_pkg.sv - shared types and widths for the writeback arbiter
package reg_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        A_PRI   = 1'b0,
        B_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/reg_wb_arbiter_wb_scoreboard.sv
// rtl/reg_wb_arbiter_wb_scoreboard.sv - pending-write bit vector for long-latency destinations
module wb_scoreboard
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 set_i,
    input  logic [ADDR_W-1:0]    set_addr_i,
    input  logic                 clr_i,
    input  logic [ADDR_W-1:0]    clr_addr_i,
    output logic [2**ADDR_W-1:0] pending_o
);

    logic [2**ADDR_W-1:0] pending_q;
    logic [2**ADDR_W-1:0] pending_d;

    // Clear first, then set, so a same-cycle reservation of a retiring register survives
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
    end

    // Pending vector register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register file write port arbiter with B starvation guard
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 a_valid_i,
    output logic                 a_ready_o,
    input  logic [ADDR_W-1:0]    a_addr_i,
    input  logic [DATA_W-1:0]    a_data_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [ADDR_W-1:0]    b_addr_i,
    input  logic [DATA_W-1:0]    b_data_i,
    input  logic                 rsv_valid_i,
    input  logic [ADDR_W-1:0]    rsv_addr_i,
    output logic                 RegWrite_o,
    output logic [ADDR_W-1:0]    RDaddr_o,
    output logic [DATA_W-1:0]    RDdata_o,
    output logic [2**ADDR_W-1:0] pending_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX - 1);
    localparam logic [3:0] STARVE_SAT = 4'd15;

    arb_state_e        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              grant_a, grant_b;
    logic              regwrite_q;
    logic [ADDR_W-1:0] rdaddr_q;
    logic [DATA_W-1:0] rddata_q;
    logic              rsv_set;

    // Grant selection, starvation count and next state; nothing granted during reset
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;
        if (!rst_i) begin
            case (state_q)
                A_PRI: begin
                    if (a_valid_i) begin
                        grant_a = 1'b1;
                    end else if (b_valid_i) begin
                        grant_b = 1'b1;
                    end
                end
                B_FORCE: begin
                    if (b_valid_i) begin
                        grant_b = 1'b1;
                    end else if (a_valid_i) begin
                        grant_a = 1'b1;
                    end
                end
                default: ;
            endcase

            if (b_valid_i && !grant_b) begin
                starve_d = (starve_q == STARVE_SAT) ? starve_q : starve_q + 4'd1;
            end else begin
                starve_d = 4'd0;
            end

            case (state_q)
                A_PRI: begin
                    if (b_valid_i && !grant_b && starve_q >= STARVE_LIM) begin
                        state_d = B_FORCE;
                    end
                end
                B_FORCE: begin
                    if (grant_b || !b_valid_i) begin
                        state_d = A_PRI;
                    end
                end
                default: state_d = A_PRI;
            endcase
        end
    end

    // Arbiter state and starvation counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= A_PRI;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Capture the winner; writes to register 0 are accepted but never enabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regwrite_q <= 1'b0;
            rdaddr_q   <= '0;
            rddata_q   <= '0;
        end else begin
            regwrite_q <= (grant_a && (a_addr_i != '0)) || (grant_b && (b_addr_i != '0));
            if (grant_a) begin
                rdaddr_q <= a_addr_i;
                rddata_q <= a_data_i;
            end else if (grant_b) begin
                rdaddr_q <= b_addr_i;
                rddata_q <= b_data_i;
            end
        end
    end

    assign rsv_set = rsv_valid_i && (rsv_addr_i != '0);

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (rsv_set),
        .set_addr_i (rsv_addr_i),
        .clr_i      (grant_b),
        .clr_addr_i (b_addr_i),
        .pending_o  (pending_o)
    );

    assign a_ready_o  = grant_a;
    assign b_ready_o  = grant_b;
    assign RegWrite_o = regwrite_q;
    assign RDaddr_o   = rdaddr_q;
    assign RDdata_o   = rddata_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, rsv_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, rsv_addr;
    logic [31:0] a_data, b_data;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] pending;

    int vectors = 0;
    int miscompares = 0;

    reg_wb_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .STARVE_MAX (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .a_valid_i   (a_valid),
        .a_ready_o   (a_ready),
        .a_addr_i    (a_addr),
        .a_data_i    (a_data),
        .b_valid_i   (b_valid),
        .b_ready_o   (b_ready),
        .b_addr_i    (b_addr),
        .b_data_i    (b_data),
        .rsv_valid_i (rsv_valid),
        .rsv_addr_i  (rsv_addr),
        .RegWrite_o  (reg_write),
        .RDaddr_o    (rd_addr),
        .RDdata_o    (rd_data),
        .pending_o   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check readies mid-cycle, then advance just past the next rising edge
    task automatic cyc(input string tag, input logic exp_a, input logic exp_b);
        @(negedge clk);
        check_vec({tag, ".a_ready"}, 64'(a_ready), 64'(exp_a));
        check_vec({tag, ".b_ready"}, 64'(b_ready), 64'(exp_b));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; rsv_valid = 1'b0;
        a_addr = 5'd0; b_addr = 5'd0; rsv_addr = 5'd0;
        a_data = '0; b_data = '0;

        // Reset: readies held low even with valid sources
        cyc("rst", 1'b0, 1'b0);
        check_vec("rst.regwrite", 64'(reg_write), 64'd0);
        check_vec("rst.rdaddr", 64'(rd_addr), 64'd0);
        check_vec("rst.rddata", 64'(rd_data), 64'd0);
        check_vec("rst.pending", 64'(pending), 64'd0);

        // Single A write
        rst = 1'b0; b_valid = 1'b0;
        a_addr = 5'd5; a_data = 32'h1234;
        cyc("a_single", 1'b1, 1'b0);
        a_valid = 1'b0;
        check_vec("a_single.regwrite", 64'(reg_write), 64'd1);
        check_vec("a_single.rdaddr", 64'(rd_addr), 64'd5);
        check_vec("a_single.rddata", 64'(rd_data), 64'h1234);
        cyc("idle0", 1'b0, 1'b0);
        check_vec("idle0.regwrite", 64'(reg_write), 64'd0);
        check_vec("idle0.rdaddr_hold", 64'(rd_addr), 64'd5);

        // Contention: A,A,A,A,B repeating
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd1; a_data = 32'hAAAA_0001;
        b_addr = 5'd2; b_data = 32'hBBBB_0002;
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("contend%0d", k), (k % 5) != 4, (k % 5) == 4);
            check_vec($sformatf("contend%0d.rdaddr", k), 64'(rd_addr), ((k % 5) == 4) ? 64'd2 : 64'd1);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        cyc("idle1", 1'b0, 1'b0);
        check_vec("idle1.regwrite", 64'(reg_write), 64'd0);

        // Scoreboard: reserve, retire, same-cycle reserve+retire
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        cyc("rsv9", 1'b0, 1'b0);
        rsv_valid = 1'b0;
        check_vec("rsv9.pending", 64'(pending), 64'h200);
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hBEEF;
        cyc("retire9", 1'b0, 1'b1);
        b_valid = 1'b0;
        check_vec("retire9.pending", 64'(pending), 64'h0);
        check_vec("retire9.rddata", 64'(rd_data), 64'hBEEF);
        rsv_valid = 1'b1; b_valid = 1'b1;
        cyc("rsv_retire9", 1'b0, 1'b1);
        rsv_valid = 1'b0;
        check_vec("rsv_retire9.pending", 64'(pending), 64'h200);
        cyc("retire9b", 1'b0, 1'b1);
        b_valid = 1'b0;
        check_vec("retire9b.pending", 64'(pending), 64'h0);
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        cyc("rsv0", 1'b0, 1'b0);
        rsv_valid = 1'b0;
        check_vec("rsv0.pending", 64'(pending), 64'h0);

        // A write to register 0 handshakes but does not write
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF;
        cyc("a_zero", 1'b1, 1'b0);
        check_vec("a_zero.regwrite", 64'(reg_write), 64'd0);

        // Starvation count restarts after B withdraws
        a_addr = 5'd1; b_addr = 5'd2; b_valid = 1'b1;
        for (int k = 0; k < 3; k++) cyc($sformatf("starve_pre%0d", k), 1'b1, 1'b0);
        b_valid = 1'b0;
        cyc("starve_gap", 1'b1, 1'b0);
        b_valid = 1'b1;
        for (int k = 0; k < 5; k++) cyc($sformatf("starve_post%0d", k), k != 4, k == 4);

        // Reset after a grant with a pending bit set
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        cyc("prerst0", 1'b1, 1'b0);
        rsv_valid = 1'b0;
        check_vec("prerst0.pending", 64'(pending), 64'h8);
        cyc("prerst1", 1'b1, 1'b0);
        cyc("prerst2", 1'b1, 1'b0);
        check_vec("prerst2.regwrite", 64'(reg_write), 64'd1);
        rst = 1'b1;
        cyc("midrst", 1'b0, 1'b0);
        check_vec("midrst.regwrite", 64'(reg_write), 64'd0);
        check_vec("midrst.pending", 64'(pending), 64'h0);
        check_vec("midrst.rdaddr", 64'(rd_addr), 64'd0);
        check_vec("midrst.rddata", 64'(rd_data), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) cyc($sformatf("postrst%0d", k), k != 4, k == 4);
        a_valid = 1'b0; b_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
